// File: rtl/inv_mix_columns.sv
// AES InvMixColumns stage: one 128-bit state per clock through the fixed inverse matrix over GF(2^8).
// Optional INV_MIX_COLUMNS_OUT_REG_EN adds an input register ahead of the matrix (latency 2 instead of 1).
module inv_mix_columns (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [0:127] original,
    output logic         out_valid,
    output logic [0:127] reverseMixed
);

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] x);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(x)));
        return x8 ^ x;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] x);
        logic [7:0] x2, x8;
        x2 = xtime(x);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ x;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] x);
        logic [7:0] x4, x8;
        x4 = xtime(xtime(x));
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // One column: bits [31:24] are a0 (the lowest-numbered byte), [7:0] are a3.
    function automatic logic [31:0] inv_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        {a0, a1, a2, a3} = col;
        b0 = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
        b1 = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
        b2 = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
        b3 = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [0:127] inv_state(input logic [0:127] s);
        logic [0:127] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[32*c +: 32] = inv_col(s[32*c +: 32]);
        end
        return r;
    endfunction

`ifdef INV_MIX_COLUMNS_OUT_REG_EN
    logic [0:127] state_p0;
    logic         vld_p0;

    // Stage 0: register the raw input state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= '0;
            vld_p0   <= 1'b0;
        end else begin
            state_p0 <= original;
            vld_p0   <= in_valid;
        end
    end

    // Stage 1: matrix on the registered state, then the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            reverseMixed <= '0;
            out_valid    <= 1'b0;
        end else begin
            reverseMixed <= inv_state(state_p0);
            out_valid    <= vld_p0;
        end
    end
`else
    // Stage 0: matrix directly on the input, single output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            reverseMixed <= '0;
            out_valid    <= 1'b0;
        end else begin
            reverseMixed <= inv_state(original);
            out_valid    <= in_valid;
        end
    end
`endif

endmodule

// File: tb/tb_inv_mix_columns.sv
// Self-checking bench for inv_mix_columns using a generic GF(2^8) matrix model.
// Works for both builds; latency follows INV_MIX_COLUMNS_OUT_REG_EN.
module tb_inv_mix_columns;

`ifdef INV_MIX_COLUMNS_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [7:0] MINV [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09},
                                           '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                                           '{8'h0d, 8'h09, 8'h0e, 8'h0b},
                                           '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    localparam logic [7:0] MFWD [4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01},
                                           '{8'h01, 8'h02, 8'h03, 8'h01},
                                           '{8'h01, 8'h01, 8'h02, 8'h03},
                                           '{8'h03, 8'h01, 8'h01, 8'h02}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [0:127] original;
    logic         out_valid;
    logic [0:127] reverseMixed;

    int total = 0;
    int bad   = 0;

    // Expected-value pipeline: model data, valid, and an optional known answer.
    logic [0:127] pd [LAT];
    logic         pv [LAT];
    logic [0:127] pk [LAT];
    logic         ph [LAT];

    inv_mix_columns dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .original     (original),
        .out_valid    (out_valid),
        .reverseMixed (reverseMixed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Generic shift-and-add GF(2^8) multiply modulo 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [0:127] mat_mul(input logic [0:127] s, input bit inv);
        logic [0:127] r;
        logic [7:0]   acc;
        logic [7:0]   coef;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    coef = inv ? MINV[row][j] : MFWD[row][j];
                    acc  = acc ^ gmul(coef, s[8*(4*c+j) +: 8]);
                end
                r[8*(4*c+row) +: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic step(input logic r, input logic v, input logic [0:127] d,
                        input logic hk, input logic [0:127] kexp);
        rst      = r;
        in_valid = v;
        original = d;
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < LAT; i++) begin
                pd[i] = '0;
                pv[i] = 1'b0;
                pk[i] = '0;
                ph[i] = 1'b0;
            end
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                pd[i] = pd[i-1];
                pv[i] = pv[i-1];
                pk[i] = pk[i-1];
                ph[i] = ph[i-1];
            end
            pd[0] = mat_mul(d, 1'b1);
            pv[0] = v;
            pk[0] = kexp;
            ph[0] = hk;
        end
        check("out_valid", {127'h0, out_valid}, {127'h0, pv[LAT-1]});
        check("model_data", reverseMixed, pd[LAT-1]);
        if (ph[LAT-1]) check("known_vector", reverseMixed, pk[LAT-1]);
    endtask

    task automatic flush();
        for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    logic [0:127] st;
    logic         v;

    initial begin
        for (int i = 0; i < LAT; i++) begin
            pd[i] = '0;
            pv[i] = 1'b0;
            pk[i] = '0;
            ph[i] = 1'b0;
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        original = '0;

        // Reset state, with a valid input held during reset that must be dropped.
        step(1'b1, 1'b1, 128'hbd6e7c3df2b5779e0b61216e8b10b689, 1'b0, '0);
        step(1'b1, 1'b0, '0, 1'b0, '0);
        check("reset_data", reverseMixed, 128'h0);
        check("reset_valid", {127'h0, out_valid}, 128'h0);

        // Single vectors.
        step(1'b0, 1'b1, 128'hbd6e7c3df2b5779e0b61216e8b10b689, 1'b1, 128'h4773b91ff72f354361cb018ea1e6cf2c);
        flush();
        step(1'b0, 1'b1, 128'hfde3bad205e5d0d73547964ef1fe37f1, 1'b1, 128'h2d7e86a339d9393ee6570a1101904e16);
        flush();
        step(1'b0, 1'b1, 128'h89d810e8855ace682d1843d8cb128fe4, 1'b1, 128'hef053f7c8b3d32fd4d2a64ad3c93071a);
        flush();

        // Back-to-back stream.
        step(1'b0, 1'b1, 128'hd1876c0f79c4300ab45594add66ff41f, 1'b1, 128'h39daee38f4f1a82aaf432410c36d45b9);
        step(1'b0, 1'b1, 128'hc62fe109f75eedc3cc79395d84f9cf5d, 1'b1, 128'h9a39bf1d05b20a3a476a0bf79fe51184);
        step(1'b0, 1'b1, 128'hc81677bc9b7ac93b25027992b0261996, 1'b1, 128'h18f78d779a93eef4f6742967c47f5ffd);
        step(1'b0, 1'b1, 128'h247240236966b3fa6ed2753288425b6c, 1'b1, 128'h85cf8bf472d124c10348f545329c0053);
        flush();

        // Algebraic corners.
        step(1'b0, 1'b1, 128'h0, 1'b1, 128'h0);
        step(1'b0, 1'b1, {4{32'h01010101}}, 1'b1, {4{32'h01010101}});
        step(1'b0, 1'b1, {4{32'h8e4da1bc}}, 1'b1, {4{32'hdb135345}});
        step(1'b0, 1'b1, {4{32'hffffffff}}, 1'b1, {4{32'hffffffff}});
        flush();

        // Reset while a stream is in flight.
        step(1'b0, 1'b1, 128'hfa636a2825b339c940668a3157244d17, 1'b0, '0);
        step(1'b1, 1'b1, 128'h4915598f55e5d7a0daca94fa1f0a63f7, 1'b0, '0);
        check("midreset_data", reverseMixed, 128'h0);
        check("midreset_valid", {127'h0, out_valid}, 128'h0);
        step(1'b0, 1'b1, 128'hfa636a2825b339c940668a3157244d17, 1'b1, 128'hfc1fc1f91934c98210fbfb8da340eb21);
        step(1'b0, 1'b1, 128'h4915598f55e5d7a0daca94fa1f0a63f7, 1'b1, 128'h076518f0b52ba2fb7a15c8d93be45e00);
        flush();

        // Round trip: forward MixColumns in the model, inverse in the DUT.
        for (int i = 0; i < 1200; i++) begin
            st = {$urandom(), $urandom(), $urandom(), $urandom()};
            v  = ($urandom_range(0, 3) != 0);
            if (i % 250 == 137)
                step(1'b1, v, mat_mul(st, 1'b0), 1'b0, '0);
            else
                step(1'b0, v, mat_mul(st, 1'b0), 1'b1, st);
        end
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
